// File: rtl/edabk_uart_tx_engine.sv
// ---------------------------------------------------------------------------------------------
// edabk_uart_tx_engine
//
// Single-clock UART transmit path: baud-rate divider, transmit FIFO and serialiser in one block.
// Characters enter through a valid/ready handshake, are queued in a small FIFO and are sent LSB
// first as START, DATA_WIDTH data bits, optional parity and one or two STOP bits. Queued
// characters are sent back to back with no idle clock between frames.
//
// Parameters
//   DATA_WIDTH  character width in bits (5..9)
//   FIFO_DEPTH  transmit FIFO entries (power of two, >= 2)
//   DIV_WIDTH   width of the baud divisor
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset; flushes the FIFO and aborts any frame
//   baud_div     clocks per bit minus 1, latched at frame start
//   parity_mode  00 none, 01 even, 10 odd, 11 mark; latched at frame start
//   stop2        1 = two stop bits; latched at frame start
//   s_valid      character offered
//   s_data       character, LSB transmitted first
//   s_ready      FIFO can accept (not full)
//   tx_out       registered serial line, idle high
//   busy         registered, high while a frame is on the line
//   frame_done   one-clock pulse on the last clock of the final stop bit
//   fifo_count   number of queued characters (the one being shifted out is not counted)
// ---------------------------------------------------------------------------------------------
module edabk_uart_tx_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic                          s_valid,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned IDX_W  = $clog2(DATA_WIDTH);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    // -----------------------------------------------------------------------------------------
    // Transmit FIFO
    // -----------------------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal index with differing
    // wrap bit means full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                        (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign head       = mem_q[rd_ptr_q[ADDR_W-1:0]];

    assign s_ready    = !fifo_full;
    assign push       = s_valid && !fifo_full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = s_data;
            wr_ptr_d                    = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage is not reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // -----------------------------------------------------------------------------------------
    // Serialiser FSM
    // -----------------------------------------------------------------------------------------
    logic [2:0]            state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [1:0]            pmode_q, pmode_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  bit_end;
    logic                  start_frame;
    logic                  frame_end;

    assign bit_end = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        div_d       = div_q;
        pmode_d     = pmode_q;
        stop2_d     = stop2_q;
        stop_idx_d  = stop_idx_q;
        start_frame = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end

            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end

            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = div_q;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d    = (pmode_q != 2'b00) ? StParity : StStop;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end

            StParity: begin
                if (bit_end) begin
                    state_d    = StStop;
                    stop_idx_d = 1'b0;
                    cnt_d      = div_q;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end

            StStop: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        cnt_d      = div_q;
                    end else begin
                        frame_end = 1'b1;
                        // Chain straight into the next start bit when more data is queued.
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Frame start: pop the head, snapshot the configuration and precompute parity on the
        // unshifted word.
        if (start_frame) begin
            state_d    = StStart;
            shift_d    = head;
            div_d      = baud_div;
            pmode_d    = parity_mode;
            stop2_d    = stop2;
            cnt_d      = baud_div;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            case (parity_mode)
                2'b01:   par_d = ^head;
                2'b10:   par_d = ~^head;
                default: par_d = 1'b1;
            endcase
        end
    end

    assign pop = start_frame;

    // Line outputs are registered from the current state, so the line trails the FSM by one
    // clock for every bit including the frame_done pulse.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
            StParity: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
        busy_d       = (state_q != StIdle);
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            div_q        <= '0;
            pmode_q      <= 2'b00;
            stop2_q      <= 1'b0;
            stop_idx_q   <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            div_q        <= div_d;
            pmode_q      <= pmode_d;
            stop2_q      <= stop2_d;
            stop_idx_q   <= stop_idx_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_edabk_uart_tx_engine.sv
// Testbench for edabk_uart_tx_engine. Expected serial waveforms are queued as stimulus is
// issued; an independent monitor captures tx_out while busy and compares on each frame_done.
module tb_edabk_uart_tx_engine;

    localparam int DW  = 8;
    localparam int FD  = 4;
    localparam int DVW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [DVW-1:0]  baud_div;
    logic [1:0]      parity_mode;
    logic            stop2;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic            s_ready;
    logic            tx_out;
    logic            busy;
    logic            frame_done;
    logic [2:0]      fifo_count;

    typedef struct {
        logic [255:0] wave;
        int           len;
        logic [7:0]   data;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    // Flow-control vectors: FIFO of 4 plus one word in flight accepts five of six.
    logic [7:0] fw[6]      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bit         exp_acc[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    int b2b_busy;
    int b2b_fd;

    edabk_uart_tx_engine #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD),
        .DIV_WIDTH (DVW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_div   (baud_div),
        .parity_mode(parity_mode),
        .stop2      (stop2),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Expected line waveform, one entry per clock, for a frame with the given settings.
    function automatic void add_frame(input logic [7:0] d, input bit has_par, input bit par_bit,
                                      input bit two_stop, input int div);
        frame_t     f;
        logic [11:0] bits;
        int          nb;
        f.wave = '0;
        f.len  = 0;
        f.data = d;
        bits   = '0;
        nb     = 0;
        bits[nb] = 1'b0;
        nb = nb + 1;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = d[i];
            nb = nb + 1;
        end
        if (has_par) begin
            bits[nb] = par_bit;
            nb = nb + 1;
        end
        bits[nb] = 1'b1;
        nb = nb + 1;
        if (two_stop) begin
            bits[nb] = 1'b1;
            nb = nb + 1;
        end
        for (int b = 0; b < nb; b++) begin
            for (int r = 0; r <= div; r++) begin
                f.wave[f.len] = bits[b];
                f.len = f.len + 1;
            end
        end
        exp_q.push_back(f);
    endfunction

    // Caller is positioned just after a rising edge; returns just after the push edge.
    task automatic push_word(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0 && fifo_count === 3'd0) && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_idle"}, {31'd0, busy}, 0);
    endtask

    // Monitor: capture the line while busy, compare against the scoreboard on frame_done.
    initial begin : monitor
        logic [255:0] cap;
        int           cap_len;
        frame_t       e;
        cap     = '0;
        cap_len = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (cap_len < 256) cap[cap_len] = tx_out;
                cap_len++;
            end else begin
                cap     = '0;
                cap_len = 0;
            end
            if (frame_done === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL frame_unexpected: got frame_done len=%0d, required no frame",
                             cap_len);
                end else begin
                    e = exp_q.pop_front();
                    if (busy !== 1'b1 || cap_len != e.len || cap !== e.wave) begin
                        n_errors++;
                        $display("FAIL frame_%02h: got len=%0d wave=%h required len=%0d wave=%h",
                                 e.data, cap_len, cap, e.len, e.wave);
                    end
                end
                cap     = '0;
                cap_len = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  t;
        int  bad;
        logic prev_ready;

        reset       = 1'b1;
        baud_div    = 16'd3;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;

        // Reset values after the first edge.
        @(posedge clk);
        #1;
        check("rst_tx", {31'd0, tx_out}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_fd", {31'd0, frame_done}, 0);
        check("rst_count", {29'd0, fifo_count}, 0);
        check("rst_ready", {31'd0, s_ready}, 1);
        step(2);
        reset = 1'b0;
        step(1);

        // Single 0xA5 frame, latency and exact busy window.
        add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 3);
        push_word(8'hA5);
        check("lat_k_count", {29'd0, fifo_count}, 1);
        check("lat_k_busy", {31'd0, busy}, 0);
        step(1);
        check("lat_k1_count", {29'd0, fifo_count}, 0);
        check("lat_k1_tx", {31'd0, tx_out}, 1);
        check("lat_k1_busy", {31'd0, busy}, 0);
        step(1);
        check("lat_k2_tx", {31'd0, tx_out}, 0);
        check("lat_k2_busy", {31'd0, busy}, 1);
        t   = 0;
        bad = 0;
        while (busy === 1'b1 && t < 200) begin
            t++;
            if (frame_done === 1'b1) bad++;
            step(1);
        end
        check("a5_busy_len", t, 40);
        check("a5_fd_count", bad, 1);
        wait_idle("a5", 100);

        // Parity: even, odd, mark on 0xAA / 0xAB.
        parity_mode = 2'b01;
        add_frame(8'hAA, 1'b1, 1'b0, 1'b0, 3);
        add_frame(8'hAB, 1'b1, 1'b1, 1'b0, 3);
        push_word(8'hAA);
        push_word(8'hAB);
        wait_idle("par_even", 300);
        parity_mode = 2'b10;
        add_frame(8'hAA, 1'b1, 1'b1, 1'b0, 3);
        add_frame(8'hAB, 1'b1, 1'b0, 1'b0, 3);
        push_word(8'hAA);
        push_word(8'hAB);
        wait_idle("par_odd", 300);
        parity_mode = 2'b11;
        add_frame(8'hAA, 1'b1, 1'b1, 1'b0, 3);
        add_frame(8'hAB, 1'b1, 1'b1, 1'b0, 3);
        push_word(8'hAA);
        push_word(8'hAB);
        wait_idle("par_mark", 300);
        parity_mode = 2'b00;

        // Flow control at baud_div=15.
        baud_div = 16'd15;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = fw[i];
            check($sformatf("fc_ready_%0d", i), {31'd0, s_ready}, {31'd0, exp_acc[i]});
            if (exp_acc[i]) add_frame(fw[i], 1'b0, 1'b0, 1'b0, 15);
            step(1);
        end
        s_valid = 1'b0;
        check("fc_full_ready", {31'd0, s_ready}, 0);
        check("fc_full_count", {29'd0, fifo_count}, 4);
        t          = 0;
        prev_ready = s_ready;
        while (frame_done !== 1'b1 && t < 400) begin
            prev_ready = s_ready;
            step(1);
            t++;
        end
        check("fc_ready_before_pop", {31'd0, prev_ready}, 0);
        check("fc_ready_after_pop", {31'd0, s_ready}, 1);
        check("fc_count_after_pop", {29'd0, fifo_count}, 3);
        wait_idle("fc", 2000);

        // Back-to-back: baud_div=0, two stop bits, 20 frames.
        baud_div = 16'd0;
        stop2    = 1'b1;
        b2b_busy = 0;
        b2b_fd   = 0;
        fork
            begin : feeder
                int   idx;
                int   guard;
                logic acc;
                idx   = 0;
                guard = 0;
                while (idx < 20 && guard < 500) begin
                    s_valid = 1'b1;
                    s_data  = idx[0] ? 8'hAB : 8'hAA;
                    @(negedge clk);
                    acc = s_ready;
                    @(posedge clk);
                    #1;
                    if (acc) begin
                        add_frame(idx[0] ? 8'hAB : 8'hAA, 1'b0, 1'b0, 1'b1, 0);
                        idx++;
                    end
                    guard++;
                end
                s_valid = 1'b0;
            end
            begin : measurer
                int w;
                w = 0;
                while (busy !== 1'b1 && w < 200) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                while (busy === 1'b1 && b2b_busy < 2000) begin
                    b2b_busy++;
                    if (frame_done === 1'b1) b2b_fd++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        check("b2b_busy_len", b2b_busy, 220);
        check("b2b_fd_count", b2b_fd, 20);
        wait_idle("b2b", 500);
        stop2 = 1'b0;

        // Config latch: parity changes mid-frame 1, applies from frame 2.
        baud_div    = 16'd3;
        parity_mode = 2'b00;
        add_frame(8'hAA, 1'b0, 1'b0, 1'b0, 3);
        add_frame(8'hAB, 1'b1, 1'b1, 1'b0, 3);
        push_word(8'hAA);
        push_word(8'hAB);
        step(10);
        parity_mode = 2'b01;
        wait_idle("latch", 300);
        parity_mode = 2'b00;

        // Reset during data bit 3 with two words still queued.
        push_word(8'h12);
        push_word(8'h34);
        push_word(8'h56);
        check("rmf_busy_start", {31'd0, busy}, 1);
        step(17);
        check("rmf_count_pre", {29'd0, fifo_count}, 2);
        reset = 1'b1;
        step(1);
        check("rmf_tx", {31'd0, tx_out}, 1);
        check("rmf_busy", {31'd0, busy}, 0);
        check("rmf_count", {29'd0, fifo_count}, 0);
        check("rmf_fd", {31'd0, frame_done}, 0);
        reset = 1'b0;
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        check("rmf_quiet", bad, 0);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/edabk_uart_tx_engine.md
# edabk_uart_tx_engine

Parametrised next-generation UART transmit path for the edabk UART transceiver. It merges the baud-rate divider, a transmit FIFO and the serialiser into one single-clock block. It adds runtime-selectable parity (none/even/odd/mark), one or two stop bits, a valid/ready input handshake and gap-free back-to-back frames. It sits between the bus-side register interface, which pushes characters, and the `tx_out` pad.

## Interface

- `DATA_WIDTH`, 8, character width in bits; legal range 5..9.
- `FIFO_DEPTH`, 4, transmit FIFO entries; power of two, minimum 2.
- `DIV_WIDTH`, 16, width of the baud divisor.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `baud_div`  in  DIV_WIDTH  clocks per bit minus 1; latched at frame start.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit forced 1); latched at frame start.
- `stop2`  in  1  1 = two stop bits, 0 = one; latched at frame start.
- `s_valid`  in  1  character offered.
- `s_data`  in  DATA_WIDTH  character; LSB transmitted first.
- `s_ready`  out  1  FIFO can accept (`!full`), combinational from FIFO state.
- `tx_out`  out  1  serial line, registered, idle high.
- `busy`  out  1  high while a frame is on the line (START..STOP), registered.
- `frame_done`  out  1  one-clock pulse on the last clock of the final stop bit.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries currently queued.

## Operation

- FIFO push: a word is written on a clock edge where `s_valid && s_ready`. FIFO pop: the FSM takes the word at frame start. Pointers wrap modulo `FIFO_DEPTH`, with an extra bit for full/empty detection.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If the FIFO is non-empty: pop the head into the shift register.
  - Latch `baud_div`, `parity_mode` and `stop2`, then go to START.
  - Otherwise hold `tx_out`=1 and `busy`=0.
- START: `tx_out`=0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - `tx_out` = shift register bit 0 for one bit period, then shift right.
  - After `DATA_WIDTH` bits, go to PARITY if the latched mode is not 00, else go to STOP.
- PARITY: one bit period.
  - Even: XOR of the data bits.
  - Odd: inverted XOR.
  - Mark: 1.
  - The XOR is computed on the original word at pop time.
- STOP:
  - `tx_out`=1 for 1 or 2 bit periods.
  - On the final clock, pulse `frame_done`.
  - If the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Bit period: a down-counter is loaded with the latched divisor at each bit start. The bit ends on the clock where the counter is 0, so each bit lasts `baud_div`+1 clocks. `baud_div`=0 gives 1 clock/bit.
- Config inputs changed mid-frame take effect only at the next frame start.
- Reset (any state, mid-frame included):
  - FIFO flushed, FSM to IDLE, counters cleared.
  - The character in flight is discarded; the frame is not completed.

## Timing

- Values on the first edge with `reset`=1: `tx_out`=1, `busy`=0, `frame_done`=0, `fifo_count`=0, `s_ready`=1 (FIFO empty).
- Latency from idle and empty: word accepted at edge k → `fifo_count`=1 after k → pop at edge k+1 → `tx_out` falls and `busy` rises after edge k+2.
- Frame length = (1 + `DATA_WIDTH` + P + S)·(`baud_div`+1) clocks. P is 0 or 1; S is 1 or 2.
- Back-to-back: the next start bit begins the clock after the final stop clock. `busy` stays high between queued frames.
- Full: `s_ready`=0; pushes are ignored. A pop frees the slot, and `s_ready`=1 from the next clock.
- Push and pop on the same edge with the FIFO non-empty: `fifo_count` unchanged.
- Empty: pop impossible; the FSM waits in IDLE. A push into an empty FIFO is never popped on the same edge.
- `fifo_count` counts only queued words; the word in the shift register is excluded.

## Test plan

- `DATA_WIDTH`=8, `baud_div`=3, parity none, 1 stop; push 0xA5 → the bench checks:
  - start low 4 clk, then bits 1,0,1,0,0,1,0,1 at 4 clk each, then stop high 4 clk;
  - `busy` high 40 clk;
  - a single `frame_done` pulse on clk 40.
- Parity: push 0xAA then 0xAB with even → parity bits 0, 1. Repeat with odd → 1, 0. Mark → 1, 1. Frame = 44 clk each at `baud_div`=3.
- Flow control: `baud_div`=15, push 6 words on consecutive clocks → 5 accepted (1 in flight + 4 queued), `s_ready`=0 and `fifo_count`=4 afterward. `s_ready` returns to 1 the clock after the next pop.
- Back-to-back: queue alternating 0xAA/0xAB, 20 frames total, with `baud_div`=0, `stop2`=1 → 11 clk per frame, no idle clock between frames, 20 `frame_done` pulses, `busy` continuously high 220 clk.
- Config latch: change `parity_mode` 00→01 during frame 1 → frame 1 has no parity bit; frame 2 carries even parity.
- Reset mid-frame: assert `reset` during the DATA bit 3 period with 2 words queued → after that edge `tx_out`=1, `busy`=0, `fifo_count`=0, no `frame_done` pulse, line stays idle afterward.
